// File: rtl/splitter_pkg.sv
// Shared definitions for the lane splitter datapaths.
package splitter_pkg;
  localparam int LANES   = 8;
  localparam int NUM_MAX = 8;

  typedef enum logic [1:0] {IDLE, DIV, DIST} state_t;
endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per step, MSB first.
module seq_divider #(
  parameter int DATAWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH:0]   rem
);
  logic [DATAWIDTH-1:0] dvd, dsr;
  logic [DATAWIDTH:0]   trial;

  // Shifted partial remainder needs the extra bit before the compare.
  assign trial = {rem[DATAWIDTH-1:0], dvd[DATAWIDTH-1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      dvd  <= '0;
      dsr  <= '0;
      quot <= '0;
      rem  <= '0;
    end else if (load) begin
      dvd  <= dividend;
      dsr  <= divisor;
      quot <= '0;
      rem  <= '0;
    end else if (step) begin
      dvd <= {dvd[DATAWIDTH-2:0], 1'b0};
      if (trial >= {1'b0, dsr}) begin
        rem  <= trial - {1'b0, dsr};
        quot <= {quot[DATAWIDTH-2:0], 1'b1};
      end else begin
        rem  <= trial;
        quot <= {quot[DATAWIDTH-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/sum_splitter.sv
// Splits total across the first num lanes; remainder goes one unit per lane from a.
module sum_splitter
  import splitter_pkg::*;
#(
  parameter int DATAWIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] total,
  input  logic [DATAWIDTH-1:0] num,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] c,
  output logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] e,
  output logic [DATAWIDTH-1:0] f,
  output logic [DATAWIDTH-1:0] g,
  output logic [DATAWIDTH-1:0] h
);
  localparam int CW = $clog2(DATAWIDTH);

  state_t                              state, nxt;
  logic [DATAWIDTH-1:0]                num_q;
  logic [CW-1:0]                       cnt;
  logic                                err_pend;
  logic                                legal, div_load, div_step;
  logic [DATAWIDTH-1:0]                quot;
  logic [DATAWIDTH:0]                  rem;
  logic [LANES-1:0][DATAWIDTH-1:0]     lane_d, lane_q;

  assign legal = (num != '0) && (num <= DATAWIDTH'(NUM_MAX));

  always_ff @(posedge Clk) begin
    if (!Rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = legal ? DIV : DIST;
      DIV:  if (cnt == CW'(DATAWIDTH-1)) nxt = DIST;
      DIST: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    div_load = (state == IDLE) && start && legal;
    div_step = (state == DIV);
  end

  seq_divider #(.DATAWIDTH(DATAWIDTH)) u_div (
    .clk(Clk), .rst(Rst), .load(div_load), .step(div_step),
    .dividend(total), .divisor(num), .quot(quot), .rem(rem)
  );

  // rem < num <= 8, so lane i gets the extra unit exactly when i < rem.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_d[gi] = (rem > (DATAWIDTH+1)'(gi))   ? quot + DATAWIDTH'(1) :
                        (num_q > DATAWIDTH'(gi))     ? quot : '0;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      num_q    <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      lane_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          num_q    <= num;
          cnt      <= '0;
          err_pend <= !legal;
        end
        DIV: cnt <= cnt + CW'(1);
        DIST: begin
          lane_q <= err_pend ? '0 : lane_d;
          err    <= err_pend;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign a = lane_q[0];
  assign b = lane_q[1];
  assign c = lane_q[2];
  assign d = lane_q[3];
  assign e = lane_q[4];
  assign f = lane_q[5];
  assign g = lane_q[6];
  assign h = lane_q[7];
endmodule

// File: tb/tb_sum_splitter.sv
// Scoreboard bench for sum_splitter: expected splits queued at accept, checked on done.
module tb_sum_splitter;
  localparam int DW = 16;

  logic          Clk = 1'b0, Rst = 1'b0, start = 1'b0;
  logic [DW-1:0] total = '0, num = '0;
  logic          busy, done, err;
  logic [DW-1:0] a, b, c, d, e, f, g, h;

  sum_splitter #(.DATAWIDTH(DW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .total(total), .num(num),
    .busy(busy), .done(done), .err(err),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0][DW-1:0] lanes;
    logic               err;
    logic               legal;
    int                 dcyc;
    logic [DW-1:0]      total;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0, npass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nchk++;
    if (obs === want) npass++;
    else $display("FAIL %s got %0d want %0d", tag, obs, want);
  endtask

  function automatic exp_t model(input logic [DW-1:0] t, input logic [DW-1:0] n, input int k);
    exp_t x;
    int   q, r;
    x.total = t;
    x.lanes = '0;
    if (n == 0 || n > 8) begin
      x.err = 1'b1; x.legal = 1'b0; x.dcyc = k + 1;
    end else begin
      x.err = 1'b0; x.legal = 1'b1; x.dcyc = k + DW + 1;
      q = int'(t) / int'(n);
      r = int'(t) % int'(n);
      for (int i = 0; i < 8; i++)
        x.lanes[i] = (i < r) ? DW'(q + 1) : (i < int'(n)) ? DW'(q) : '0;
    end
    return x;
  endfunction

  task automatic do_req(input logic [DW-1:0] t, input logic [DW-1:0] n, output int k);
    int w = 0;
    k = -1;
    @(negedge Clk);
    while (busy && w < 100) begin @(negedge Clk); w++; end
    if (busy) begin chk("busy_timeout", 1, 0); return; end
    start = 1'b1; total = t; num = n;
    @(posedge Clk); #1;
    k = cyc;
    sb.push_back(model(t, n, k));
    start = 1'b0;
  endtask

  // Monitor: every done must match the oldest outstanding request.
  exp_t               ex;
  logic [7:0][DW-1:0] obs;
  int                 sum;
  always @(negedge Clk) begin
    if (Rst && done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        ex  = sb.pop_front();
        obs = {h, g, f, e, d, c, b, a};
        sum = 0;
        for (int i = 0; i < 8; i++) begin
          chk($sformatf("lane%0d t=%0d", i, ex.total), obs[i], ex.lanes[i]);
          sum += int'(obs[i]);
        end
        chk("err", err, ex.err);
        chk("latency", cyc, ex.dcyc);
        chk("busy_in_done", busy, 0);
        if (ex.legal) chk("lane_sum", sum, ex.total);
      end
    end
  end

  int k1, k2, kx, w;
  initial begin
    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_lanes", {a, b, c, d, e, f, g, h}, 0);
    Rst = 1'b1;

    do_req(100, 8, kx);
    do_req(7, 3, kx);
    do_req(50, 0, kx);
    do_req(50, 9, kx);
    do_req(8, 2, kx);
    do_req(65535, 1, kx);
    do_req(65535, 7, kx);

    // start while busy must be ignored
    do_req(100, 3, kx);
    repeat (3) @(negedge Clk);
    chk("busy_mid", busy, 1);
    start = 1'b1; total = 200; num = 5;
    @(negedge Clk);
    start = 1'b0;

    // Back-to-back: second accept on the done edge of the first
    do_req(10, 4, k1);
    do_req(20, 5, k2);
    chk("no_bubble", k2, k1 + DW + 2);

    for (int i = 0; i < 6; i++)
      do_req(DW'($urandom_range(65535, 0)), DW'($urandom_range(9, 0)), kx);

    // Reset during DIV aborts the op
    do_req(50, 3, kx);
    repeat (5) @(negedge Clk);
    Rst = 1'b0;
    sb.delete();
    @(negedge Clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_lanes", {a, b, c, d, e, f, g, h}, 0);
    Rst = 1'b1;
    repeat (20) @(negedge Clk);
    chk("abort_lanes_hold", {a, b, c, d, e, f, g, h}, 0);
    do_req(9, 4, kx);

    w = 0;
    while (sb.size() != 0 && w < 100) begin @(negedge Clk); w++; end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge Clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/sum_splitter.md
# sum_splitter

Sequential splitter that distributes a DATAWIDTH-bit total across eight lane outputs `a`..`h`. The first `num` lanes receive equal shares, and any remainder is spread one unit at a time starting at lane `a`. It is the distribution-side counterpart to the 8-input sum/average datapath and uses the same lane names, `num` operand and DATAWIDTH parameterisation. Division is iterative (one quotient bit per cycle) with a start/busy/done handshake.

## Interface
- DATAWIDTH, 16, width of `total`, `num` and every lane output.
- Clk  input  1  rising-edge clock; single clock domain.
- Rst  input  1  synchronous reset, active-low; sampled on rising `Clk`.
- start  input  1  request pulse; accepted only when `busy`=0.
- total  input  DATAWIDTH  unsigned value to split; sampled on the accept edge.
- num  input  DATAWIDTH  unsigned lane count, legal range 1..8; sampled on the accept edge.
- busy  output  1  high from the accept edge until the edge that raises `done`.
- done  output  1  one-cycle pulse; lane outputs and `err` are valid from this cycle.
- err  output  1  illegal `num` (0 or >8) on the last request; held until the next `done`.
- a,b,c,d,e,f,g,h  output  DATAWIDTH  registered lane shares.

## Operation
- States: IDLE, DIV, DIST.
- IDLE, `start`=1, legal `num`:
  - latch `total` and `num`;
  - clear quotient, remainder and bit counter;
  - go to DIV; `busy`=1.
- IDLE, `start`=1, illegal `num`: go directly to DIST with the error flag set.
- DIV: restoring division, MSB first, one bit per edge.
  - remainder = {remainder, next dividend bit}.
  - If remainder ≥ `num`, subtract `num` and set the quotient bit to 1.
  - After DATAWIDTH iterations, go to DIST.
- DIST: one edge, registers all outputs, pulses `done`, clears `busy`, returns to IDLE.
  - Quotient q, remainder r; r < num ≤ 8.
  - Lane i (a=0 … h=7) receives q+1 if i < r, q if r ≤ i < num, else 0.
  - q+1 cannot overflow because r > 0 implies q < 2^DATAWIDTH−1.
  - Error case: all lanes 0, `err`=1.
  - Normal case: `err`=0.
- Invariant (legal `num`): sum of lanes == `total`.
- All arithmetic is unsigned; the remainder register is DATAWIDTH+1 bits wide to hold the shifted compare.
- `start` while `busy`=1 is ignored: no queuing, latched operands unchanged.
- Lane outputs and `err` hold their last values between `done` pulses.

## Timing
- Reset (Rst=0 at a rising edge): state IDLE; `busy`, `done`, `err`=0; `a`..`h`=0; quotient, remainder and counter cleared.
- Reset mid-DIV or mid-DIST aborts the operation; no `done` is produced.
- Legal request accepted at edge k:
  - DIV occupies edges k+1..k+DATAWIDTH;
  - outputs and `done`=1 appear after edge k+DATAWIDTH+1 (17 for DATAWIDTH=16);
  - `done` falls after the following edge.
- Illegal request accepted at edge k: `done`=1, `err`=1 and zero lanes after edge k+1.
- Back-to-back requests: `start` may be high in the cycle `done`=1, because `busy`=0 in that cycle. It is accepted on that edge, so there are no idle bubbles between operations.
- Throughput: one split per DATAWIDTH+2 cycles.

## Structure
- Shared package `splitter_pkg`:
  - `LANES`=8;
  - state enum {IDLE, DIV, DIST};
  - `NUM_MAX`=8.
- Sub-module `seq_divider`:
  - restoring unsigned divider with `load`/`step` inputs and `quot`/`rem` outputs;
  - parameterised by DATAWIDTH;
  - reusable by other iterative datapaths in the codebase.
- Top-level `sum_splitter`: FSM, operand latches, legality check, and eight-lane distribution compare/select.

## Test plan
- total=100, num=8 → `a`..`d`=13, `e`..`h`=12, `err`=0; `done` 17 cycles after accept; lane sum 100.
- total=7, num=3 → `a`=3, `b`=2, `c`=2, `d`..`h`=0, `err`=0.
- num=0, then num=9 (total=50) → each gives `done` 1 cycle after accept, `err`=1, all lanes 0. A following legal request (total=8, num=2) gives `a`=`b`=4, `err`=0.
- total=65535, num=1 → `a`=65535, others 0. total=65535, num=7 → `a`..`g`=9362 with a 1 added to `a` (r=1), i.e. `a`=9363, `b`..`g`=9362.
- `start` pulsed again while `busy`=1 (total=200) → ignored; the first result is unchanged. `start` held high in the `done` cycle → a second op is accepted with no bubble.
- Rst=0 asserted at DIV cycle 5 → next cycle `busy`=0, `done` never pulses, all lanes 0. A fresh request then completes normally.
